key_event_fifo: RTL
===================

KEY_EVENT_FIFO -- requirements
Module: key_event_fifo

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset.
REQ-002 Parameter DEPTH SHALL default to 8 and SHALL set the FIFO entry count; legal values are powers of two from 2 to 16.
REQ-003 Parameter INT_CYCLES SHALL default to 3 and SHALL set the mcu_int pulse width in clk cycles; legal values are 1 to 15.
REQ-004 Port clk  in  1  is the system clock (MCU clock domain).
REQ-005 Port rst_n  in  1  is the synchronous active-low reset.
REQ-006 Port key_int  in  1  is the key-press strobe from the keypad driver; it is level and may be high for several cycles.
REQ-007 Port key_data  in  4  is the keypad code; it is valid whenever key_int is high.
REQ-008 Port rd_en  in  1  is the MCU read strobe (pop and acknowledge).
REQ-009 Port ovf_clr  in  1  clears the overflow flag.
REQ-010 Port dout  out  4  is the head entry (first-word-fall-through); it reads 0 when the FIFO is empty.
REQ-011 Port count  out  5  is the number of occupied entries.
REQ-012 Port empty  out  1  and port full  out  1  are the FIFO status flags.
REQ-013 Port overflow  out  1  is a sticky flag indicating a dropped key.
REQ-014 Port mcu_int  out  1  is the interrupt pulse to the MCU.

Function
REQ-015 A push SHALL occur only on the cycle where key_int is high and its registered previous value is low (one push per strobe), and SHALL capture key_data from that cycle.
REQ-016 A pushed entry SHALL be visible on dout, count, and empty on the clock after the edge cycle.
REQ-017 A push while full with no simultaneous valid pop SHALL be dropped; the FIFO contents SHALL remain unchanged and overflow SHALL set.
REQ-018 rd_en while not empty SHALL pop the head; rd_en while empty SHALL have no effect on the pointers or count.
REQ-019 A simultaneous push and pop SHALL leave count unchanged; this includes the full case, where the push is accepted.
REQ-020 The read and write pointers SHALL wrap modulo DEPTH; full SHALL equal (count==DEPTH) and empty SHALL equal (count==0).
REQ-021 The interrupt FSM SHALL have the states IDLE, PULSE, and HOLD, with mcu_int high only in PULSE.
REQ-022 In IDLE, the FSM SHALL go to PULSE when the FIFO is not empty, so mcu_int rises one clock after empty falls.
REQ-023 The FSM SHALL stay in PULSE for exactly INT_CYCLES cycles and then go to HOLD.
REQ-024 In HOLD, the FSM SHALL go to IDLE on rd_en, or when the FIFO becomes empty.
REQ-025 rd_en during PULSE SHALL end the pulse and SHALL return the FSM to IDLE on the next clock.
REQ-026 After returning to IDLE with entries remaining, the FSM SHALL issue a new pulse; the result is one interrupt per unread entry.
REQ-027 ovf_clr SHALL clear overflow; an overflow event in the same cycle SHALL win, leaving overflow set.
REQ-028 All outputs SHALL be registered or derived directly from registers, with no combinational path from key_int or rd_en to any output.

Reset
REQ-029 While rst_n is low at a clock edge, the FIFO SHALL empty, pointers SHALL zero, overflow SHALL clear, and the FSM SHALL go to IDLE.
REQ-030 Reset values SHALL be: dout=0, count=0, empty=1, full=0, overflow=0, mcu_int=0.
REQ-031 The key_int history register SHALL reset to 1, so a strobe already high when reset is released is not captured.
REQ-032 Reset asserted mid-pulse SHALL drop mcu_int on the next clock; entries in flight SHALL be discarded.

Configuration
REQ-033 When macro KEY_FIFO_OVF_EN is defined, the overflow flag and ovf_clr SHALL behave as specified in REQ-017 and REQ-027.
REQ-034 When KEY_FIFO_OVF_EN is undefined, overflow SHALL be tied to 0 and ovf_clr SHALL be ignored; dropping when full is unchanged and the port list is identical.

Verification
REQ-035 Scenario: key_int high for 5 cycles with key_data=4'h7 -> exactly one push; then count=1, dout=7, and mcu_int high for 3 cycles starting one clock after empty falls.
REQ-036 Scenario: 9 strobes with codes 1..9, no reads -> count=8 and full=1; code 9 is dropped; overflow=1 with the macro and 0 without it; 8 reads return 1..8 in order.
REQ-037 Scenario: FIFO full plus a strobe with code A and rd_en in the same cycle -> count stays 8; the old head is popped; A is stored as the tail.
REQ-038 Scenario: 3 entries, rd_en asserted after each pulse -> exactly 3 mcu_int pulses; empty=1 after the third read; no further pulse.
REQ-039 Scenario: rst_n low during the second cycle of a pulse with 2 entries, key_int held high across release -> mcu_int=0 and count=0 after the edge; no capture until key_int falls and rises again.
REQ-040 Scenario: ovf_clr and an overflow event in the same cycle -> overflow=1 (macro defined).

Source files
------------

// File: rtl/key_event_fifo_if.sv
// Keypad-event FIFO bus: keypad strobe/code and MCU read side in, FIFO status and interrupt out.
interface key_event_fifo_if;
  localparam int unsigned KW = 4;
  localparam int unsigned CW = 5;

  logic          key_int;
  logic [KW-1:0] key_data;
  logic          rd_en;
  logic          ovf_clr;
  logic [KW-1:0] dout;
  logic [CW-1:0] count;
  logic          empty;
  logic          full;
  logic          overflow;
  logic          mcu_int;

  modport master (
    output key_int, key_data, rd_en, ovf_clr,
    input  dout, count, empty, full, overflow, mcu_int
  );

  modport slave (
    input  key_int, key_data, rd_en, ovf_clr,
    output dout, count, empty, full, overflow, mcu_int
  );
endinterface

// File: rtl/key_event_fifo.sv
// Keypad event FIFO with one-push-per-strobe capture and an MCU interrupt pulse per unread entry.
// Optional sticky overflow flag enabled by defining KEY_FIFO_OVF_EN.
module key_event_fifo #(
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned INT_CYCLES = 3
) (
  input logic             clk,
  input logic             rst_n,
  key_event_fifo_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned KW = 4;
  localparam int unsigned CW = 5;
  localparam int unsigned PW = 4;

  typedef enum logic [1:0] {IDLE, PULSE, HOLD} state_t;

  state_t        state, state_n;
  logic [PW-1:0] pcnt, pcnt_n;
  logic          mcu_int_q;

  logic          key_prev;
  logic [KW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, rd_ptr_inc_c;
  logic [CW-1:0] count_q, count_n_c;
  logic [KW-1:0] dout_q, head_n_c;
  logic          empty_q, full_q, overflow_q;

  logic push_c, pop_c, wr_c;

  // Rising edge of the level strobe is the only push request.
  assign push_c       = bus.key_int & ~key_prev;
  assign pop_c        = bus.rd_en & ~empty_q;
  assign wr_c         = push_c & (~full_q | pop_c);
  assign rd_ptr_inc_c = rd_ptr + AW'(1);

  always_comb begin
    count_n_c = count_q;
    case ({wr_c, pop_c})
      2'b10:   count_n_c = count_q + CW'(1);
      2'b01:   count_n_c = count_q - CW'(1);
      default: count_n_c = count_q;
    endcase
  end

  // Next head value so dout can be a plain register (reads 0 when empty).
  always_comb begin
    head_n_c = dout_q;
    if (count_n_c == '0) begin
      head_n_c = '0;
    end else if (pop_c) begin
      head_n_c = (count_q == CW'(1)) ? bus.key_data : mem[rd_ptr_inc_c];
    end else if (empty_q) begin
      head_n_c = bus.key_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && wr_c) begin
      mem[wr_ptr] <= bus.key_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      key_prev <= 1'b1;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      dout_q   <= '0;
    end else begin
      key_prev <= bus.key_int;
      if (wr_c) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop_c) begin
        rd_ptr <= rd_ptr_inc_c;
      end
      count_q <= count_n_c;
      empty_q <= (count_n_c == '0);
      full_q  <= (count_n_c == CW'(DEPTH));
      dout_q  <= head_n_c;
    end
  end

`ifdef KEY_FIFO_OVF_EN
  logic ovf_ev_c;
  assign ovf_ev_c = push_c & full_q & ~pop_c;

  // A drop in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overflow_q <= 1'b0;
    end else if (ovf_ev_c) begin
      overflow_q <= 1'b1;
    end else if (bus.ovf_clr) begin
      overflow_q <= 1'b0;
    end
  end
`else
  logic unused_ovf_clr;
  assign unused_ovf_clr = bus.ovf_clr;

  always_ff @(posedge clk) begin
    overflow_q <= 1'b0;
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      pcnt      <= '0;
      mcu_int_q <= 1'b0;
    end else begin
      state     <= state_n;
      pcnt      <= pcnt_n;
      mcu_int_q <= (state_n == PULSE);
    end
  end

  // Interrupt sequencing: one pulse per visit to IDLE while entries remain.
  always_comb begin
    state_n = state;
    pcnt_n  = pcnt;
    case (state)
      IDLE: begin
        if (!empty_q) begin
          state_n = PULSE;
          pcnt_n  = '0;
        end
      end
      PULSE: begin
        if (bus.rd_en) begin
          state_n = IDLE;
        end else if (pcnt == PW'(INT_CYCLES - 1)) begin
          state_n = HOLD;
        end else begin
          pcnt_n = pcnt + PW'(1);
        end
      end
      HOLD: begin
        if (bus.rd_en || empty_q) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.dout     = dout_q;
  assign bus.count    = count_q;
  assign bus.empty    = empty_q;
  assign bus.full     = full_q;
  assign bus.overflow = overflow_q;
  assign bus.mcu_int  = mcu_int_q;
endmodule
